// File: rtl/multi_cycle_processor.sv
// Four-clock-per-instruction 32-bit RISC core (IF, ID, EX, WB) with an internal
// instruction ROM and register file; its only inputs are clock and reset.
module multi_cycle_processor #(
   parameter int IMEM_WORDS = 64,
   parameter int NREGS      = 32
) (
   input  logic clk,
   input  logic reset
);

   localparam int          IW      = $clog2(IMEM_WORDS);
   localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

   localparam logic [1:0] S_IF = 2'd0;
   localparam logic [1:0] S_ID = 2'd1;
   localparam logic [1:0] S_EX = 2'd2;
   localparam logic [1:0] S_WB = 2'd3;

   logic [1:0]  state, state_nxt;
   logic [31:0] pc, ir, a, b, alu_out;
   logic [31:0] regfile [NREGS];
   logic [31:0] imem [IMEM_WORDS];

   logic        ld_ir, ld_ab, ld_alu, wr_en;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wr_dst;
   logic        is_r, is_i;
   logic [31:0] rs_val, rt_val;

   function automatic logic [31:0] alu(input logic [31:0] ins,
                                       input logic [31:0] x,
                                       input logic [31:0] y);
      logic [31:0] imm_s;
      imm_s = {{16{ins[15]}}, ins[15:0]};
      alu   = '0;
      if (ins[31:26] == 6'h00) begin
         case (ins[5:0])
            6'h20:   alu = x + y;
            6'h22:   alu = x - y;
            6'h24:   alu = x & y;
            6'h25:   alu = x | y;
            6'h2A:   alu = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: alu = '0;
         endcase
      end else if (ins[31:26] == 6'h08) begin
         alu = x + imm_s;
      end else if (ins[31:26] == 6'h0C) begin
         alu = x & {16'h0000, ins[15:0]};
      end
   endfunction

   // Program ROM: everything outside the first three words is a write-to-r0 NOP.
   always_comb begin
      for (int i = 0; i < IMEM_WORDS; i++) imem[i] = '0;
      imem[0] = 32'h0022_1820;
      imem[1] = 32'h0061_2022;
      imem[2] = 32'h0081_2825;
   end

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign funct = ir[5:0];

   assign is_r   = (op == 6'h00) && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                     funct == 6'h25 || funct == 6'h2A);
   assign is_i   = (op == 6'h08) || (op == 6'h0C);
   assign wr_dst = is_r ? rd : rt;
   assign rs_val = (rs == 5'd0) ? 32'd0 : regfile[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : regfile[rt];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IF;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_IF;
      case (state)
         S_IF:    state_nxt = S_ID;
         S_ID:    state_nxt = S_EX;
         S_EX:    state_nxt = S_WB;
         default: state_nxt = S_IF;
      endcase
   end

   always_comb begin
      ld_ir  = 1'b0;
      ld_ab  = 1'b0;
      ld_alu = 1'b0;
      wr_en  = 1'b0;
      case (state)
         S_IF:    ld_ir  = 1'b1;
         S_ID:    ld_ab  = 1'b1;
         S_EX:    ld_alu = 1'b1;
         default: wr_en  = (is_r || is_i) && (wr_dst != 5'd0);
      endcase
   end

   // Reset aborts any in-flight instruction: WB never fires while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         for (int i = 0; i < NREGS; i++) regfile[i] <= 32'(i);
      end else begin
         if (ld_ir) begin
            ir <= imem[pc[IW+1:2]];
            pc <= (pc + 32'd4) & PC_MASK;
         end
         if (ld_ab) begin
            a <= rs_val;
            b <= rt_val;
         end
         if (ld_alu) alu_out <= alu(ir, a, b);
         if (wr_en)  regfile[wr_dst] <= alu_out;
      end
   end

endmodule

// File: tb/tb_multi_cycle_processor.sv
// Bench for multi_cycle_processor: instruction-level reference model, per-cycle
// compare of the architectural state, literal anchors and randomized reset pulses.
module tb_multi_cycle_processor;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   chk_en = 1'b0;

   multi_cycle_processor #(.IMEM_WORDS(64), .NREGS(32)) dut (
      .clk   (clk),
      .reset (reset)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] m_reg [32];
   logic [31:0] m_pc, m_ir, m_a, m_b, m_alu;
   int          m_ph;

   function automatic logic [31:0] rom(input int idx);
      case (idx)
         0:       return 32'h00221820;
         1:       return 32'h00612022;
         2:       return 32'h00812825;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_exec(input logic [31:0] ins,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
      int op, fn;
      op = int'(ins[31:26]);
      fn = int'(ins[5:0]);
      if (op == 0 && fn == 32) return x + y;
      if (op == 0 && fn == 34) return x - y;
      if (op == 0 && fn == 36) return x & y;
      if (op == 0 && fn == 37) return x | y;
      if (op == 0 && fn == 42) return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      if (op == 8)  return x + {{16{ins[15]}}, ins[15:0]};
      if (op == 12) return x & {16'h0, ins[15:0]};
      return 32'd0;
   endfunction

   function automatic int m_dest(input logic [31:0] ins);
      int op, fn;
      op = int'(ins[31:26]);
      fn = int'(ins[5:0]);
      if (op == 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 42))
         return int'(ins[15:11]);
      if (op == 8 || op == 12) return int'(ins[20:16]);
      return 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ph = 0; m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0;
         for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
      end else begin
         case (m_ph)
            0: begin
               m_ir = rom(int'(m_pc) / 4);
               m_pc = (m_pc + 32'd4) % 32'd256;
            end
            1: begin
               m_a = m_reg[m_ir[25:21]];
               m_b = m_reg[m_ir[20:16]];
            end
            2: m_alu = m_exec(m_ir, m_a, m_b);
            default: if (m_dest(m_ir) != 0) m_reg[m_dest(m_ir)] = m_alu;
         endcase
         m_ph = (m_ph + 1) % 4;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("state", 32'(dut.state), 32'(m_ph));
         check("pc", dut.pc, m_pc);
         check("ir", dut.ir, m_ir);
         check("a", dut.a, m_a);
         check("b", dut.b, m_b);
         check("alu_out", dut.alu_out, m_alu);
         for (int i = 0; i < 32; i++)
            check($sformatf("regfile[%0d]", i), dut.regfile[i], m_reg[i]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Asynchronous reset mid-clock, observed before any edge
      #2 reset = 1'b0;
      #1;
      check("rst_state", 32'(dut.state), 32'd0);
      check("rst_pc", dut.pc, 32'd0);
      check("rst_r3", dut.regfile[3], 32'd3);
      check("rst_r31", dut.regfile[31], 32'd31);
      chk_en = 1'b1;
      #19 reset = 1'b1;

      tick(4);
      check("add_ir", dut.ir, 32'h00221820);
      check("add_pc", dut.pc, 32'd4);
      check("add_r3", dut.regfile[3], 32'd3);
      check("add_state", 32'(dut.state), 32'd0);
      tick(4);
      check("sub_r4", dut.regfile[4], 32'd2);
      tick(4);
      check("or_r5", dut.regfile[5], 32'd3);
      check("or_pc", dut.pc, 32'd12);
      tick(12);
      check("nop_pc", dut.pc, 32'd24);
      check("nop_r0", dut.regfile[0], 32'd0);
      check("nop_r6", dut.regfile[6], 32'd6);

      // Abort the SUB after its second clock
      @(negedge clk) reset = 1'b0;
      @(negedge clk) #2 reset = 1'b1;
      tick(4);
      tick(2);
      #2 reset = 1'b0;
      #1;
      check("abort_r4", dut.regfile[4], 32'd4);
      check("abort_pc", dut.pc, 32'd0);
      @(negedge clk) #2 reset = 1'b1;
      tick(4);
      check("rerun_ir", dut.ir, 32'h00221820);
      check("rerun_r3", dut.regfile[3], 32'd3);

      // 64 instructions from reset: PC wraps back to 0
      tick(252);
      check("wrap_pc", dut.pc, 32'd0);
      tick(1);
      check("wrap_ir", dut.ir, 32'h00221820);
      check("wrap_pc4", dut.pc, 32'd4);

      // Randomized asynchronous reset pulses, model tracks each one
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(1, 40)) @(posedge clk);
         #($urandom_range(1, 4)) reset = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         @(negedge clk) #($urandom_range(1, 3)) reset = 1'b1;
      end
      tick(40);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
